// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
// Holds the FSM state encoding, the port-owner encoding, the RAM
// write-enable encodings and the default address/data widths.
package mem_arb_pkg;

  // Default widths: 9-bit word-pair address, two 10-bit words of data.
  localparam int unsigned MEM_ARB_AW = 9;
  localparam int unsigned MEM_ARB_DW = 20;

  // Access sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_WR      = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Which requester owns the access in flight.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DP = 1'b1
  } owner_e;

  // RAM WriteEnable encodings: bit 0 selects the low word, bit 1 the high word.
  typedef enum logic [1:0] {
    WE_NONE = 2'b00,
    WE_LO   = 2'b01,
    WE_HI   = 2'b10,
    WE_BOTH = 2'b11
  } we_e;

  // True when a write-enable pattern touches at least one word.
  function automatic logic is_write(input logic [1:0] we);
    return we != WE_NONE;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select between the fetch port and
// the data port. A lone requester always wins.
// Build option MEM_ARB_RR_EN: when defined, a tie goes to the port that was
// not granted last (round robin); otherwise the data port always wins a tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   dp_req,
`ifdef MEM_ARB_RR_EN
  input  owner_e last_owner,
`endif
  output logic   grant_valid,
  output owner_e grant_owner
);

  // Pick the owner for the next access from the pending requests.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant_valid = if_req | dp_req;
    grant_owner = OWN_DP;
    if (if_req && !dp_req) begin
      grant_owner = OWN_IF;
    end
`ifdef MEM_ARB_RR_EN
    else if (if_req && dp_req && (last_owner == OWN_DP)) begin
      grant_owner = OWN_IF;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one dual-word RAM between the instruction-fetch port
// (read-only) and the load/store data port (read/write). Each access is
// sequenced IDLE -> RD -> DONE or IDLE -> WR -> WR_WAIT -> DONE, with a
// one-cycle acknowledge to the owning port in DONE.
// ram_wdata is what goes onto the RAM's shared data pins while ram_we != 0;
// ram_rdata is what those pins carry back while ram_we == 0.
// Build option MEM_ARB_RR_EN: round-robin tie-break with a last-owner
// register; without it the data port has fixed priority and the last-owner
// register does not exist.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = MEM_ARB_AW,
  parameter int unsigned DW = MEM_ARB_DW
) (
  input  logic          clk,
  input  logic          reset_n,
  // Instruction-fetch port
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  // Load/store data port
  input  logic          dp_req,
  input  logic [1:0]    dp_we,
  input  logic [AW-1:0] dp_addr,
  input  logic [DW-1:0] dp_wdata,
  output logic          dp_ack,
  output logic [DW-1:0] dp_rdata,
  // RAM side
  output logic [AW-1:0] ram_addr,
  output logic [1:0]    ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  input  logic          ram_ready
);

  state_e        state_q,    state_d;
  owner_e        owner_q,    owner_d;
  logic [AW-1:0] addr_q,     addr_d;
  we_e           we_q,       we_d;
  logic [DW-1:0] wdata_q,    wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dp_rdata_q, dp_rdata_d;
  logic          if_ack_q,   if_ack_d;
  logic          dp_ack_q,   dp_ack_d;

  logic          grant_valid;
  owner_e        grant_owner;

`ifdef MEM_ARB_RR_EN
  owner_e        last_owner_q, last_owner_d;
`endif

  mem_arb_pick u_pick (
    .if_req      (if_req),
    .dp_req      (dp_req),
`ifdef MEM_ARB_RR_EN
    .last_owner  (last_owner_q),
`endif
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // Next-state and next-register computation for the access sequencer.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dp_rdata_d = dp_rdata_q;
    if_ack_d   = 1'b0;
    dp_ack_d   = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // Grants wait for the RAM to be ready so a new access never lands
        // inside a write-recovery window.
        if (ram_ready && grant_valid) begin
          owner_d = grant_owner;
          if (grant_owner == OWN_DP) begin
            addr_d  = dp_addr;
            we_d    = we_e'(dp_we);
            wdata_d = dp_wdata;
          end else begin
            addr_d  = if_addr;
            we_d    = WE_NONE;
          end
          state_d = is_write(we_d) ? ST_WR : ST_RD;
`ifdef MEM_ARB_RR_EN
          last_owner_d = grant_owner;
`endif
        end
      end

      ST_RD: begin
        // Combinational RAM read: capture straight into the owner's register;
        // the other port's rdata is left untouched.
        if (owner_q == OWN_DP) begin
          dp_rdata_d = ram_rdata;
          dp_ack_d   = 1'b1;
        end else begin
          if_rdata_d = ram_rdata;
          if_ack_d   = 1'b1;
        end
        state_d = ST_DONE;
      end

      ST_WR: begin
        // Write enable is up for exactly this one cycle.
        state_d = ST_WR_WAIT;
      end

      ST_WR_WAIT: begin
        // Hold off the acknowledge until the RAM finishes write recovery.
        if (ram_ready) begin
          state_d = ST_DONE;
          if (owner_q == OWN_DP) begin
            dp_ack_d = 1'b1;
          end else begin
            if_ack_d = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously on reset_n low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      we_q       <= WE_NONE;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dp_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      dp_ack_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= OWN_IF;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values together.
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dp_rdata_q <= dp_rdata_d;
      if_ack_q   <= if_ack_d;
      dp_ack_q   <= dp_ack_d;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  // RAM controls decode from state and latched fields; write enable only in WR,
  // so an asynchronous reset drops it immediately.
  assign ram_addr  = addr_q;
  assign ram_we    = (state_q == ST_WR) ? we_q : WE_NONE;
  assign ram_wdata = wdata_q;

  assign if_ack    = if_ack_q;
  assign dp_ack    = dp_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dp_rdata  = dp_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a
// behavioural dual-word RAM (one-cycle write recovery on ready).
// Build option MEM_ARB_RR_EN changes the expected tie-break order.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 9;
  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dp_req;
  logic [1:0]    dp_we;
  logic [AW-1:0] dp_addr;
  logic [DW-1:0] dp_wdata;
  logic          dp_ack;
  logic [DW-1:0] dp_rdata;
  logic [AW-1:0] ram_addr;
  logic [1:0]    ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          ram_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .dp_req    (dp_req),
    .dp_we     (dp_we),
    .dp_addr   (dp_addr),
    .dp_wdata  (dp_wdata),
    .dp_ack    (dp_ack),
    .dp_rdata  (dp_rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_ready (ram_ready)
  );

  // Behavioural RAM: 10-bit words, pair a = {word 2a+1, word 2a}.
  logic [9:0] mem [0:1023];
  logic       ram_loaded = 1'b0;
  logic       ram_busy   = 1'b0;
  logic       force_ready_low = 1'b0;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int k = 0; k < 1024; k++) mem[k] <= (k <= 20) ? 10'(k) : 10'd0;
      mem[0]     <= 10'h014;
      ram_loaded <= 1'b1;
    end else begin
      if (ram_we[0]) mem[{ram_addr, 1'b0}] <= ram_wdata[9:0];
      if (ram_we[1]) mem[{ram_addr, 1'b1}] <= ram_wdata[19:10];
    end
    ram_busy <= (ram_we != 2'b00);
  end

  assign ram_rdata = {mem[{ram_addr, 1'b1}], mem[{ram_addr, 1'b0}]};
  assign ram_ready = !ram_busy && !force_ready_low;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Count negedges until the port's ack (-1 on timeout) and cycles with ram_we != 0.
  task automatic wait_ack(input owner_e port, output int cyc, output int we_cyc);
    cyc    = -1;
    we_cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ram_we != 2'b00) we_cyc++;
      if ((port == OWN_DP) ? dp_ack : if_ack) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Fetch from IDLE; returns at the negedge of the following IDLE cycle.
  task automatic do_fetch(input logic [AW-1:0] addr, output int cyc);
    int wc;
    if_req  = 1'b1;
    if_addr = addr;
    wait_ack(OWN_IF, cyc, wc);
    if_req  = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_dp(input logic [1:0] we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, output int cyc, output int we_cyc);
    dp_req   = 1'b1;
    dp_we    = we;
    dp_addr  = addr;
    dp_wdata = wdata;
    wait_ack(OWN_DP, cyc, we_cyc);
    dp_req   = 1'b0;
    @(negedge clk);
  endtask

`ifdef MEM_ARB_RR_EN
  localparam int N_TIE = 4;
`else
  localparam int N_TIE = 2;
`endif
  int exp_tie_cyc [4] = '{2, 5, 8, 11};
  int exp_tie_own [4] = '{1, 0, 1, 0};
  int got_cyc [4];
  int got_own [4];
  int n_got;

  initial begin
    int cyc, wc;
    reset_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dp_req = 1'b0; dp_we = 2'b00; dp_addr = '0; dp_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_if_ack", if_ack, 0);
    check("rst_dp_ack", dp_ack, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dp_rdata", dp_rdata, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1. Fetch reads
    do_fetch(9'd0, cyc);
    check("fetch0_cyc", cyc, 2);
    check("fetch0_hold", if_rdata, 20'h00414);
    check("fetch0_dp_untouched", dp_rdata, 0);
    do_fetch(9'd1, cyc);
    check("fetch1_cyc", cyc, 2);
    check("fetch1_data", if_rdata, 20'h00C02);

    // 2. Low-word write, then fetch sees merged pair
    do_dp(WE_LO, 9'd0, 20'h003FF, cyc, wc);
    check("wr_lo_cyc", cyc, 4);
    check("wr_lo_we_cycles", wc, 1);
    check("wr_lo_wdata", ram_wdata, 20'h003FF);
    do_fetch(9'd0, cyc);
    check("fetch0_after_wr", if_rdata, 20'h007FF);

    // 3. Both-word write, then data-port readback
    do_dp(WE_BOTH, 9'd3, 20'hABCDE, cyc, wc);
    check("wr_both_cyc", cyc, 4);
    do_dp(WE_NONE, 9'd3, 20'h00000, cyc, wc);
    check("dp_rd_cyc", cyc, 2);
    check("dp_rd_we_cycles", wc, 0);
    check("dp_rd_data", dp_rdata, 20'hABCDE);
    check("if_rdata_unchanged", if_rdata, 20'h007FF);

    // 4. Tie on address 1 (reset first so last-owner starts at fetch)
    reset_n = 1'b0;
    @(negedge clk);
    check("rst2_dp_rdata", dp_rdata, 0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin got_cyc[k] = -1; got_own[k] = -1; end
    n_got  = 0;
    if_req = 1'b1; if_addr = 9'd1;
    dp_req = 1'b1; dp_we = WE_NONE; dp_addr = 9'd1;
    for (int i = 1; i <= 40 && n_got < N_TIE; i++) begin
      @(negedge clk);
      if (dp_ack) begin
        got_own[n_got] = 1; got_cyc[n_got] = i; n_got++;
`ifndef MEM_ARB_RR_EN
        dp_req = 1'b0;
`endif
      end
      if (if_ack && n_got < 4) begin
        got_own[n_got] = 0; got_cyc[n_got] = i; n_got++;
      end
    end
    if_req = 1'b0; dp_req = 1'b0;
    @(negedge clk);
    check("tie_ack_count", n_got, N_TIE);
    for (int k = 0; k < N_TIE; k++) begin
      check($sformatf("tie_owner%0d", k), got_own[k], exp_tie_own[k]);
      check($sformatf("tie_cycle%0d", k), got_cyc[k], exp_tie_cyc[k]);
    end
    check("tie_dp_data", dp_rdata, 20'h00C02);
    check("tie_if_data", if_rdata, 20'h00C02);

    // 5. ready held low for 3 cycles: no grant until it returns
    force_ready_low = 1'b1;
    dp_req = 1'b1; dp_we = WE_BOTH; dp_addr = 9'd4; dp_wdata = 20'h12345;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check($sformatf("nrdy_we%0d", i), ram_we, 0);
      check($sformatf("nrdy_addr%0d", i), ram_addr, 1);
      check($sformatf("nrdy_ack%0d", i), dp_ack, 0);
    end
    force_ready_low = 1'b0;
    @(negedge clk);
    check("rdy_grant_we", ram_we, WE_BOTH);
    check("rdy_grant_addr", ram_addr, 4);
    wait_ack(OWN_DP, cyc, wc);
    dp_req = 1'b0;
    @(negedge clk);
    check("rdy_wr_ack_cyc", cyc, 3);
    do_dp(WE_NONE, 9'd4, 20'h00000, cyc, wc);
    check("rdy_readback", dp_rdata, 20'h12345);

    // 6. Reset asserted while in WR
    dp_req = 1'b1; dp_we = WE_BOTH; dp_addr = 9'd5; dp_wdata = 20'h0AAAA;
    @(negedge clk);
    check("midrst_in_wr", ram_we, WE_BOTH);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_ram_we", ram_we, 0);
    check("midrst_dp_ack", dp_ack, 0);
    check("midrst_if_ack", if_ack, 0);
    check("midrst_ram_addr", ram_addr, 0);
    check("midrst_dp_rdata", dp_rdata, 0);
    dp_req = 1'b0;
    if_req = 1'b1; if_addr = 9'd2;
    @(negedge clk);
    reset_n = 1'b1;
    wait_ack(OWN_IF, cyc, wc);
    if_req = 1'b0;
    check("postrst_fetch_cyc", cyc, 2);
    check("postrst_fetch_data", if_rdata, 20'h01404);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter for the 10-bit CPU. It shares the single dual-word RAM between the instruction-fetch unit (read-only) and the load/store unit (read/write). It sequences each RAM access: it drives address and write-enable, waits out the RAM's write-recovery cycle on `ready`, and returns read data with a one-cycle acknowledge pulse. It sits between the CPU core and the RAM. The top level converts the split `ram_wdata`/`ram_rdata` buses onto the RAM's bidirectional `data` bus.

## Interface
Parameters:
- `AW`, 9, word-pair address width (RAM `Address_in`)
- `DW`, 20, data width (two 10-bit words)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request, held until `if_ack`
- `if_addr`  in  AW  fetch address
- `if_ack`  out  1  one-cycle completion pulse
- `if_rdata`  out  DW  fetch data, valid while `if_ack`=1, held afterwards
- `dp_req`  in  1  data-port request, held until `dp_ack`
- `dp_we`  in  2  00 read, 01 low word, 10 high word, 11 both
- `dp_addr`  in  AW  data-port address
- `dp_wdata`  in  DW  write data
- `dp_ack`  out  1  one-cycle completion pulse
- `dp_rdata`  out  DW  read data, valid while `dp_ack`=1, held afterwards
- `ram_addr`  out  AW  to RAM `Address_in`
- `ram_we`  out  2  to RAM `WriteEnable`
- `ram_wdata`  out  DW  driven onto RAM `data` when `ram_we`≠0
- `ram_rdata`  in  DW  RAM `data` when reading (combinational read)
- `ram_ready`  in  1  RAM `ready`

## Operation
- FSM states: IDLE, RD, WR, WR_WAIT, DONE.
- IDLE: if `ram_ready`=1 and any request is pending, pick a winner and latch owner, address, `we`, and `wdata`. `if_*` requests always latch `we`=00.
  - Latched `we`=00: go to RD.
  - Otherwise: go to WR.
  - If `ram_ready`=0 or there is no request: stay in IDLE.
- RD: `ram_addr`=latched address, `ram_we`=00. At the clock edge, capture `ram_rdata` into the owner's rdata register, then go to DONE.
- WR: `ram_we`=latched `we`, `ram_wdata`=latched data, for exactly one cycle, then go to WR_WAIT.
- WR_WAIT: `ram_we`=00. Stay while `ram_ready`=0; go to DONE on the first cycle `ram_ready`=1.
- DONE: the owner's ack is 1 for this single cycle, then go to IDLE. The requester must drop or replace its request in the cycle after it sees ack.
- Arbitration: without the configuration macro, the data port has fixed priority. A lone requester is always granted.
- Write data for read-only or partial writes: the unwritten word in RAM is unchanged. The arbiter never merges words.
- The non-owner's rdata register is never modified.
- `ram_addr` and `ram_we` are decoded from state plus latched registers. `ram_we` is 00 in every state except WR.

## Timing
- Reset values: FSM=IDLE, `if_ack`=`dp_ack`=0, `if_rdata`=`dp_rdata`=0, `ram_addr`=0, `ram_we`=00, `ram_wdata`=0, last-owner=fetch.
- Read: request seen in IDLE at cycle 0, RD at cycle 1, ack at cycle 2. Back-to-back reads from one port run at one per 3 cycles.
- Write: IDLE at cycle 0, WR at cycle 1, WR_WAIT at cycles 2..n while `ram_ready`=0, ack the cycle after `ram_ready` returns to 1. With the standard RAM, ack is at cycle 4.
- Simultaneous requests in IDLE: exactly one grant. The loser stays pending and is granted on the next IDLE in which it is still requested.
- A request that drops before ack is undefined. A request that rises during an access waits for IDLE.
- Reset mid-operation: outputs return to reset values asynchronously and `ram_we` drops immediately. A write interrupted in WR is not guaranteed committed.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. On a tie, the port not granted last wins. The last-owner register updates on every grant.
- Not defined: fixed data-port priority. The last-owner register and its logic are omitted, and fetch may starve under continuous `dp_req`.

## Structure
- Package `mem_arb_pkg`: FSM state enum, owner encoding (OWN_IF, OWN_DP), `we` encodings (WE_NONE, WE_LO, WE_HI, WE_BOTH), default `AW`/`DW`.
- One sub-module, `mem_arb_pick`: combinational winner select from `if_req`, `dp_req` and last-owner, with the `MEM_ARB_RR_EN` choice inside it.

## Test plan
Bench uses the standard RAM model with init word k = k for k=0..20, except word 0 = 0x014.
1. Fetch read: `if_addr`=0 -> `if_ack` at cycle 2, `if_rdata`=20'h00414. `if_addr`=1 -> 20'h00C02.
2. Write low word: `dp_we`=01, `dp_addr`=0, `dp_wdata`=20'h003FF -> `ram_we`=01 for one cycle, `dp_ack` at cycle 4. A following fetch of address 0 returns 20'h007FF.
3. Write both words: `dp_we`=11, `dp_addr`=3, `dp_wdata`=20'hABCDE. A following `dp_we`=00 read of address 3 -> `dp_rdata`=20'hABCDE, and `if_rdata` is unchanged.
4. Tie: both ports request address 1. Without the macro, `dp_ack` comes first, then `if_ack` 3 cycles later. With `MEM_ARB_RR_EN`, grants alternate over 4 repeated ties starting with the data port.
5. `ram_ready` forced low for 3 cycles in IDLE -> no grant, `ram_we`=00. The grant occurs in the first cycle `ram_ready`=1.
6. Assert `reset_n`=0 during WR -> `ram_we`=00 and both acks 0 immediately. After release, the FSM is in IDLE and a pending fetch completes normally.
